// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer for the single-ported 128x32
// data SRAM. Port 0 is the processor data port, port 1 the loader/debug port.
// Each granted access becomes a registered, active-low CEN/WEN/OEN pin
// sequence; read data returns with a one-cycle rvalid pulse.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin tie breaking.
// When it is undefined, port 0 has fixed priority and no pointer flop exists.
module dmem_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [6:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [6:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        CEN,
    output logic        WEN,
    output logic        OEN,
    output logic [6:0]  A,
    output logic [31:0] Data2Mem,
    input  logic [31:0] ReadDataMem
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Counter preload: the last WAIT cycle is the one where the counter is 0.
    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    state_t      r_state;
    logic        r_port;
    logic        r_we;
    logic [1:0]  r_cnt;
`ifdef DMEM_ARB_RR_EN
    logic        r_last;
`endif

    logic        w_any_req;
    logic        w_win;
    logic        w_win_we;
    logic [6:0]  w_win_addr;
    logic [31:0] w_win_wdata;

    // Choose the winning port among the current requests.
    always_comb begin
        w_any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
            w_win = ~r_last;
`else
            w_win = 1'b0;
`endif
        end else if (m1_req) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end

    // Route the winning port's command toward the pin registers.
    always_comb begin
        if (w_win) begin
            w_win_we    = m1_we;
            w_win_addr  = m1_addr;
            w_win_wdata = m1_wdata;
        end else begin
            w_win_we    = m0_we;
            w_win_addr  = m0_addr;
            w_win_wdata = m0_wdata;
        end
    end

    // Sequencer: arbitrate, drive the SRAM pins, count latency, return data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_cnt     <= 2'd0;
            CEN       <= 1'b1;
            WEN       <= 1'b1;
            OEN       <= 1'b1;
            A         <= 7'd0;
            Data2Mem  <= 32'd0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
`ifdef DMEM_ARB_RR_EN
            r_last    <= 1'b1;
`endif
        end else begin
            // Pulses and pin strobes are inactive unless a state below asserts them.
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            CEN       <= 1'b1;
            WEN       <= 1'b1;
            OEN       <= 1'b1;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_any_req) begin
                        r_state  <= ST_ISSUE;
                        r_port   <= w_win;
                        r_we     <= w_win_we;
                        CEN      <= 1'b0;
                        WEN      <= ~w_win_we;
                        OEN      <= w_win_we;
                        A        <= w_win_addr;
                        Data2Mem <= w_win_wdata;
                        m0_gnt   <= ~w_win;
                        m1_gnt   <= w_win;
`ifdef DMEM_ARB_RR_EN
                        r_last   <= w_win;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (r_we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= LAT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= ST_RESP;
                        if (r_port) begin
                            m1_rdata  <= ReadDataMem;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= ReadDataMem;
                            m0_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
